// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/multiply ALU between two requesters.
// Each transaction moves through IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// The response carries the result and the id of the requester that issued it.
module alu_share_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ALU_LATENCY = 0
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,

    output logic             busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gnt0_c;
    logic               gnt1_c;

    // Round-robin choice: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt0_c = req0_valid && (!req1_valid || last_grant_q);
        gnt1_c = req1_valid && (!req0_valid || !last_grant_q);
    end

    // State and captured-transaction registers; reset discards any in-flight work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic, transaction capture and the combinational ready handshake.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready is masked during reset so no handshake appears while held.
                req0_ready = gnt0_c && !reset;
                req1_ready = gnt1_c && !reset;
                if (gnt0_c) begin
                    op_d         = req0_op;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_ISSUE;
                end else if (gnt1_c) begin
                    op_d         = req1_op;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ALU_LATENCY == 0) begin
                    data_d  = alu_result;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_W'(ALU_LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = alu_result;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state; operands hold their last issued values.
    always_comb begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_op     = op_q;
        alu_start  = (state_q == S_ISSUE);
        resp_valid = (state_q == S_RESP);
        resp_id    = id_q;
        resp_data  = data_q;
        busy       = (state_q != S_IDLE);
    end

endmodule
